// File: rtl/board_rst_pkg.sv
// board_rst_pkg: shared definitions for the board reset sequencer.
//   ST_* : FSM state encodings, also visible on board_reset_seq.state_o
//   max3 : largest of three cycle parameters, used to size the phase counter
package board_rst_pkg;

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_DEV_REL   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_SW_RST    = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// lock_sync: multi-stage synchroniser for a vector of asynchronous lock flags.
//   sys_clk : destination clock
//   rst     : synchronous active-low clear of every stage
//   i_lock  : asynchronous lock flags
//   o_lock  : flags after SYNC_STAGES flops
module lock_sync #(
    parameter int NUM_LOCKS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [NUM_LOCKS-1:0] i_lock,
    output logic [NUM_LOCKS-1:0] o_lock
);

    logic [SYNC_STAGES-1:0][NUM_LOCKS-1:0] r_stage;

    // Stage 0 takes the raw pin; each later stage shifts up by one.
    always_ff @(posedge sys_clk) begin
        if (!rst)
            r_stage <= '0;
        else
            r_stage <= {r_stage[SYNC_STAGES-2:0], i_lock};
    end

    assign o_lock = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/board_reset_seq.sv
// board_reset_seq: board-level reset and clock-lock sequencer.
//   sys_clk         : system clock
//   rst             : synchronous active-low reset
//   pll_locked_i    : asynchronous PLL/MMCM lock flags
//   sw_rst_req_i    : software reset request (level, sys_clk domain)
//   pll_rst_o       : reset to the clock primitives
//   dev_rst_o       : peripheral reset
//   core_rst_o      : CPU core reset
//   ready_o         : high only in RUN
//   state_o         : current FSM state
//   lock_loss_cnt_o : saturating count of lock-loss events
module board_reset_seq
    import board_rst_pkg::*;
#(
    parameter int NUM_LOCKS      = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 8,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CORE_DELAY     = 16,
    parameter int LOSS_CNT_WIDTH = 8
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic [NUM_LOCKS-1:0]      pll_locked_i,
    input  logic                      sw_rst_req_i,
    output logic                      pll_rst_o,
    output logic                      dev_rst_o,
    output logic                      core_rst_o,
    output logic                      ready_o,
    output logic [2:0]                state_o,
    output logic [LOSS_CNT_WIDTH-1:0] lock_loss_cnt_o
);

    localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, STABLE_CYCLES, CORE_DELAY)) + 1;
    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY - 1);

    logic [NUM_LOCKS-1:0]      w_locks;
    logic                      w_all_locked;
    logic                      w_loss;
    logic [2:0]                w_next;
    logic [CNT_W-1:0]          w_cnt;
    logic [2:0]                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [LOSS_CNT_WIDTH-1:0] r_loss;
    logic                      r_pll_rst;
    logic                      r_dev_rst;
    logic                      r_core_rst;
    logic                      r_ready;

    lock_sync #(
        .NUM_LOCKS   (NUM_LOCKS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .sys_clk (sys_clk),
        .rst     (rst),
        .i_lock  (pll_locked_i),
        .o_lock  (w_locks)
    );

    assign w_all_locked = &w_locks;
    // Lock loss only matters once the peripherals have been let out of reset.
    assign w_loss = (r_state == ST_DEV_REL || r_state == ST_RUN) && !w_all_locked;

    // Lock loss outranks a software request arriving in the same cycle.
    always_comb begin
        w_next = ST_PLL_RST;
        case (r_state)
            ST_PLL_RST:   w_next = (r_cnt == PLL_LAST) ? ST_WAIT_LOCK : ST_PLL_RST;
            ST_WAIT_LOCK: w_next = (w_all_locked && r_cnt == STABLE_LAST) ? ST_DEV_REL : ST_WAIT_LOCK;
            ST_DEV_REL:   w_next = w_loss ? ST_PLL_RST : sw_rst_req_i ? ST_SW_RST :
                                   (r_cnt == CORE_LAST) ? ST_RUN : ST_DEV_REL;
            ST_RUN:       w_next = w_loss ? ST_PLL_RST : sw_rst_req_i ? ST_SW_RST : ST_RUN;
            ST_SW_RST:    w_next = (r_cnt == PLL_LAST) ? ST_WAIT_LOCK : ST_SW_RST;
            default:      w_next = ST_PLL_RST;
        endcase
    end

    // Counter restarts on every transition and whenever the locks drop while waiting;
    // RUN has no timed exit so the counter just sits at zero there.
    assign w_cnt = (w_next != r_state || r_state == ST_RUN ||
                    (r_state == ST_WAIT_LOCK && !w_all_locked)) ? '0 : r_cnt + 1'b1;

    // Outputs are decoded from the next state so they change together with state_o.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            r_state    <= ST_PLL_RST;
            r_cnt      <= '0;
            r_loss     <= '0;
            r_pll_rst  <= 1'b1;
            r_dev_rst  <= 1'b1;
            r_core_rst <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt;
            r_loss     <= r_loss + LOSS_CNT_WIDTH'(w_loss && !(&r_loss));
            r_pll_rst  <= (w_next == ST_PLL_RST);
            r_dev_rst  <= !(w_next == ST_DEV_REL || w_next == ST_RUN);
            r_core_rst <= (w_next != ST_RUN);
            r_ready    <= (w_next == ST_RUN);
        end
    end

    assign pll_rst_o       = r_pll_rst;
    assign dev_rst_o       = r_dev_rst;
    assign core_rst_o      = r_core_rst;
    assign ready_o         = r_ready;
    assign state_o         = r_state;
    assign lock_loss_cnt_o = r_loss;

endmodule
